// File: rtl/cv32e_data_pkg.sv
// Shared widths and transaction types for the CV32E data-interface initiator.
package cv32e_data_pkg;

  localparam int unsigned CV32E_ADDR_W = 32;
  localparam int unsigned CV32E_DATA_W = 32;
  localparam int unsigned CV32E_BE_W   = CV32E_DATA_W / 8;

  typedef struct packed {
    logic                    we;
    logic [CV32E_ADDR_W-1:0] addr;
    logic [CV32E_BE_W-1:0]   be;
    logic [CV32E_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [CV32E_DATA_W-1:0] rdata;
    logic                    we;
    logic                    err;
  } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is presented combinationally.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i & ~empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push    = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e_data_initiator.sv
// OBI-style data-bus master: one-deep request register, in-order buffered responses.
module cv32e_data_initiator
  import cv32e_data_pkg::*;
#(
  parameter int unsigned RSP_DEPTH  = 2,
  parameter int unsigned ADDR_WIDTH = CV32E_ADDR_W,
  parameter int unsigned DATA_WIDTH = CV32E_DATA_W
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_we_o,
  output logic                    rsp_err_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i,
  output logic                    busy_o,
  output logic                    proto_err_o
);

  // Handshake: cmd and rsp transfer on a rising edge where valid and ready are both high;
  // valid never depends on ready. Bus address phase completes on data_req_o & data_gnt_i.

  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned USED_W = CNT_W + 2;

  cmd_t              req_q;
  logic              req_valid_q;
  logic              proto_err_q;
  logic              accept, granted, rsp_push, rsp_pop;
  logic              out_we, out_full, out_empty;
  logic [CNT_W-1:0]  out_count, rsp_count;
  logic              rsp_full, rsp_empty;
  rsp_t              rsp_in, rsp_out;
  logic [USED_W-1:0] used;
  logic              unused_full;

  // Slots are reserved at command accept, so every bus response already has FIFO room.
  assign used        = USED_W'(req_valid_q) + USED_W'(out_count) + USED_W'(rsp_count);
  assign cmd_ready_o = (~req_valid_q | data_gnt_i) & (used < USED_W'(RSP_DEPTH));
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign granted     = req_valid_q & data_gnt_i;
  assign rsp_push    = data_rvalid_i & ~out_empty;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  assign unused_full = out_full | rsp_full;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
    end else if (accept) begin
      req_valid_q <= 1'b1;
      req_q       <= '{we: cmd_we_i, addr: cmd_addr_i, be: cmd_be_i, wdata: cmd_wdata_i};
    end else if (granted) begin
      req_valid_q <= 1'b0;
    end
  end

  // A beat with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) proto_err_q <= 1'b0;
    else if (data_rvalid_i & out_empty) proto_err_q <= 1'b1;
  end

  sync_fifo #(.WIDTH(1), .DEPTH(RSP_DEPTH)) u_out_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (granted),
    .push_data_i (req_q.we),
    .pop_i       (rsp_push),
    .pop_data_o  (out_we),
    .full_o      (out_full),
    .empty_o     (out_empty),
    .count_o     (out_count)
  );

  always_comb begin
    rsp_in       = '0;
    rsp_in.rdata = out_we ? '0 : data_rdata_i;
    rsp_in.we    = out_we;
    rsp_in.err   = data_err_i;
  end

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (rsp_push),
    .push_data_i (rsp_in),
    .pop_i       (rsp_pop),
    .pop_data_o  (rsp_out),
    .full_o      (rsp_full),
    .empty_o     (rsp_empty),
    .count_o     (rsp_count)
  );

  assign rsp_valid_o  = ~rsp_empty;
  assign rsp_rdata_o  = rsp_out.rdata;
  assign rsp_we_o     = rsp_out.we;
  assign rsp_err_o    = rsp_out.err;
  assign data_req_o   = req_valid_q;
  assign data_addr_o  = req_q.addr;
  assign data_we_o    = req_q.we;
  assign data_be_o    = req_q.be;
  assign data_wdata_o = req_q.wdata;
  assign busy_o       = (used != '0);
  assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_cv32e_data_initiator.sv
// Scoreboard bench: command/bus/response model with a randomized slave and in-order expected queue.
module tb_cv32e_data_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [BW-1:0] cmd_be_i = '0;
  logic [DW-1:0] cmd_wdata_i = '0;
  logic          rsp_valid_o, rsp_ready_i = 1'b0, rsp_we_o, rsp_err_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          data_req_o, data_gnt_i = 1'b0, data_we_o;
  logic [AW-1:0] data_addr_o;
  logic [BW-1:0] data_be_o;
  logic [DW-1:0] data_wdata_o, data_rdata_i = '0;
  logic          data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic          busy_o, proto_err_o;

  always #5 clk_i = ~clk_i;

  cv32e_data_initiator #(.RSP_DEPTH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } bus_cmd_t;

  bus_cmd_t        cmd_q[$];      // accepted, not yet seen on the bus
  logic [DW:0]     slv_q[$];      // {rdata, err} the slave still owes
  logic [DW+1:0]   exp_q[$];      // expected {rdata, we, err} at the response port
  logic [DW-1:0]   mem_model [16];
  int              checks = 0, errors = 0;
  int              gnt_mode = 1, rvalid_en = 1, rdy_mode = 1;
  bit              rand_err_en = 0, force_err = 0, spur = 0;
  bit              stall_prev = 0;
  bus_cmd_t        stall_cmd, cur, c;
  logic [DW-1:0]   bus_rd, exp_rd;
  logic            bus_err;
  logic [DW+1:0]   got;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Monitor and model: sampled mid-cycle, describing what the next rising edge will do.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      stall_prev = 0;
    end else begin
      cur = '{we: data_we_o, addr: data_addr_o, be: data_be_o, wdata: data_wdata_o};
      if (stall_prev) begin
        chk("req_held", data_req_o, 1'b1);
        chk("fields_held", cur, stall_cmd);
      end
      stall_prev = data_req_o & ~data_gnt_i;
      stall_cmd  = cur;
      if (data_req_o && data_gnt_i) begin
        if (cmd_q.size() == 0) fail("grant_without_cmd");
        else begin
          c = cmd_q.pop_front();
          chk("bus_fields", cur, c);
          bus_err = force_err || (rand_err_en && $urandom_range(0, 7) == 0);
          force_err = 0;
          if (c.we) begin
            for (int b = 0; b < BW; b++)
              if (c.be[b]) mem_model[c.addr[5:2]][8*b +: 8] = c.wdata[8*b +: 8];
            bus_rd = $urandom;
            exp_rd = '0;
          end else begin
            bus_rd = bus_err ? '0 : mem_model[c.addr[5:2]];
            exp_rd = bus_rd;
          end
          slv_q.push_back({bus_rd, bus_err});
          exp_q.push_back({exp_rd, c.we, bus_err});
        end
      end
      if (cmd_valid_i && cmd_ready_o)
        cmd_q.push_back('{we: cmd_we_i, addr: cmd_addr_i, be: cmd_be_i, wdata: cmd_wdata_i});
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) fail("rsp_unexpected");
        else begin
          got = exp_q.pop_front();
          chk("rsp_data", {rsp_rdata_o, rsp_we_o, rsp_err_o}, got);
        end
      end
    end
  end

  // Slave and response-consumer drivers.
  always @(posedge clk_i) begin
    #2;
    if (!reset_i) begin
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0; data_err_i = 0; rsp_ready_i = 0;
    end else begin
      case (gnt_mode)
        0:       data_gnt_i = 1'($urandom_range(0, 1));
        1:       data_gnt_i = 1'b1;
        default: data_gnt_i = 1'b0;
      endcase
      rsp_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      if (spur) begin
        data_rvalid_i = 1; data_rdata_i = $urandom; data_err_i = 0;
      end else if (slv_q.size() > 0 &&
                   (rvalid_en == 2 || (rvalid_en == 1 && $urandom_range(0, 3) != 0))) begin
        {data_rdata_i, data_err_i} = slv_q.pop_front();
        data_rvalid_i = 1;
      end else begin
        data_rvalid_i = 0; data_rdata_i = $urandom; data_err_i = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [AW-1:0] addr,
                          input logic [BW-1:0] be, input logic [DW-1:0] wdata);
    bit ok = 0;
    cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wdata;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) begin ok = 1; break; end
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 0;
    if (!ok) fail("cmd_accept_timeout");
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_q.size() == 0 && exp_q.size() == 0 && slv_q.size() == 0) begin done = 1; break; end
      @(posedge clk_i); #1;
    end
    if (!done) fail("drain_timeout");
    else chk("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    #500000;
    fail("global_watchdog");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    mem_model[0] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs",
        {data_req_o, rsp_valid_o, busy_o, proto_err_o, rsp_rdata_o, data_addr_o}, '0);
    reset_i = 1;
    @(posedge clk_i); #1;
    chk("ready_after_reset", cmd_ready_o, 1'b1);

    // Single load, granted immediately.
    gnt_mode = 1; rvalid_en = 1; rdy_mode = 1;
    send_cmd(0, 32'h100, 4'hF, '0);
    chk("req_latency", data_req_o, 1'b1);
    chk("req_addr", data_addr_o, 32'h100);
    @(posedge clk_i); #1;
    chk("req_dropped_after_gnt", data_req_o, 1'b0);
    drain();

    // Grant stall on a store, then read it back.
    gnt_mode = 2;
    send_cmd(1, 32'h204, 4'hF, 32'h1234_5678);
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_req", data_req_o, 1'b1);
      chk("stall_ready", cmd_ready_o, 1'b0);
    end
    @(posedge clk_i); #1;
    gnt_mode = 1;
    drain();
    send_cmd(0, 32'h204, 4'hF, '0);
    drain();

    // Back-pressure: two loads fill every slot, a third waits for a pop.
    rdy_mode = 0; rvalid_en = 2;
    send_cmd(0, 32'h10, 4'hF, '0);
    send_cmd(0, 32'h14, 4'hF, '0);
    cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 32'h18; cmd_be_i = 4'hF; cmd_wdata_i = '0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    chk("full_ready", cmd_ready_o, 1'b0);
    chk("full_rsp_valid", rsp_valid_o, 1'b1);
    chk("full_busy", busy_o, 1'b1);
    @(posedge clk_i); #1;
    rdy_mode = 1;
    @(posedge clk_i); #1;
    rdy_mode = 0;
    @(negedge clk_i);
    chk("ready_after_pop", cmd_ready_o, 1'b1);
    @(posedge clk_i); #1;
    cmd_valid_i = 0;
    rdy_mode = 2; rvalid_en = 1;
    drain();

    // Error response, then a clean transaction.
    rdy_mode = 1;
    force_err = 1;
    send_cmd(0, 32'h30, 4'hF, '0);
    drain();
    send_cmd(0, 32'h34, 4'hF, '0);
    drain();

    // Randomized traffic.
    gnt_mode = 0; rvalid_en = 1; rdy_mode = 2; rand_err_en = 1;
    for (int n = 0; n < 300; n++) begin
      send_cmd(1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
               4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
    end
    drain();
    rand_err_en = 0; gnt_mode = 1; rdy_mode = 1;

    // Spurious rvalid while idle.
    spur = 1;
    @(posedge clk_i); #1;
    spur = 0;
    @(negedge clk_i);
    chk("proto_err_set", proto_err_o, 1'b1);
    chk("proto_busy", busy_o, 1'b0);
    chk("proto_no_rsp", rsp_valid_o, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    chk("proto_err_sticky", proto_err_o, 1'b1);
    reset_i = 0;
    @(posedge clk_i); #1;
    reset_i = 1;
    chk("proto_err_cleared", proto_err_o, 1'b0);

    // Asynchronous reset while a request waits for grant.
    gnt_mode = 2;
    send_cmd(1, 32'h40, 4'h3, 32'hCAFE_F00D);
    @(posedge clk_i); #3;
    chk("pending_req", data_req_o, 1'b1);
    reset_i = 0;
    #1;
    chk("async_req_drop", data_req_o, 1'b0);
    chk("async_busy_drop", busy_o, 1'b0);
    cmd_q.delete(); exp_q.delete(); slv_q.delete();
    @(posedge clk_i); #1;
    gnt_mode = 1;
    reset_i = 1;
    chk("ready_after_async", cmd_ready_o, 1'b1);
    chk("idle_after_async", {busy_o, data_req_o}, 2'b00);
    spur = 1;
    @(posedge clk_i); #1;
    spur = 0;
    @(negedge clk_i);
    chk("late_rvalid_proto", proto_err_o, 1'b1);
    send_cmd(0, 32'h8, 4'hF, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
